// File: rtl/lcd_cmd_seq.sv
`timescale 1ns/1ps
// lcd_cmd_seq
// Command sequencer in front of the LCD controller. Host commands are queued
// in a small FIFO and issued one at a time when the controller is not busy.
// A Load command also streams the image bytes from a 1-cycle-latency memory
// onto datain, aligned with the controller's load window.
//
// Ports
//   clk        : clock, all logic on the rising edge
//   reset      : asynchronous reset, active low
//   host_cmd   : host command code (0 Reflash, 1 Load, 2 Right, 3 Left, 4 Up, 5 Down)
//   host_valid : host offers host_cmd this cycle
//   host_ready : FIFO not full (push when host_valid & host_ready)
//   img_rd     : image memory read strobe
//   img_addr   : image memory address
//   img_data   : image memory read data, valid the cycle after img_rd
//   busy       : controller busy
//   cmd        : command to controller, holds its last value between issues
//   cmd_valid  : one-cycle issue strobe
//   datain     : image byte to controller (pass-through of img_data)
//   cmd_done   : one-cycle pulse when an issued command completes
//   cmd_err    : one-cycle pulse when an illegal code (6, 7) is dropped
module lcd_cmd_seq #(
    parameter int FIFO_DEPTH = 4,
    parameter int IMG_BYTES  = 36
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] host_cmd,
    input  logic       host_valid,
    output logic       host_ready,
    output logic       img_rd,
    output logic [5:0] img_addr,
    input  logic [7:0] img_data,
    input  logic       busy,
    output logic [2:0] cmd,
    output logic       cmd_valid,
    output logic [7:0] datain,
    output logic       cmd_done,
    output logic       cmd_err
);

    localparam int               PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int               CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [2:0]       CMD_LOAD  = 3'd1;
    localparam logic [5:0]       LAST_ADDR = 6'(IMG_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_GUARD,
        S_WAIT
    } state_t;

    state_t state, state_nxt;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [2:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic [2:0]       head;
    logic             head_illegal;

    // Ready comes from the registered count only, so a full FIFO refuses a
    // push even in a cycle where it is also popping.
    assign host_ready   = count < DEPTH_C;
    assign push         = host_valid & host_ready;
    assign fifo_empty   = (count == '0);
    assign head         = fifo_mem[rd_ptr];
    assign head_illegal = (head >= 3'd6);

    // NOTE: storage has no reset; validity is tracked by count, so resetting
    // the array would only cost flops and reset routing.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= host_cmd;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------
    logic issue;     // IDLE decided to issue the head next cycle
    logic err_now;   // illegal head dropped this cycle
    logic done_now;  // issued command completes this cycle

    // NOTE: every output of this block gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        issue     = 1'b0;
        err_now   = 1'b0;
        done_now  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    if (head_illegal) begin
                        pop     = 1'b1;
                        err_now = 1'b1;
                    end else if (!busy) begin
                        issue     = 1'b1;
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // Head is consumed while it is on the cmd port.
                pop       = 1'b1;
                state_nxt = S_GUARD;
            end
            S_GUARD: begin
                // Controller raises busy one cycle after cmd_valid; ignore it here.
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (!busy && !img_rd) begin
                    done_now  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cmd       <= 3'd0;
            cmd_valid <= 1'b0;
            cmd_done  <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cmd_valid <= issue;
            cmd_done  <= done_now;
            cmd_err   <= err_now;
            if (issue) begin
                cmd <= head;
            end
        end
    end

    // ------------------------------------------------------------------
    // Image stream: address k is presented in issue cycle T+k, so the
    // memory returns byte k on datain at T+1+k. The counter stops at the
    // last address instead of wrapping.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            img_rd   <= 1'b0;
            img_addr <= 6'd0;
        end else if (issue && (head == CMD_LOAD)) begin
            img_rd   <= 1'b1;
            img_addr <= 6'd0;
        end else if (img_rd) begin
            if (img_addr == LAST_ADDR) begin
                img_rd <= 1'b0;
            end else begin
                img_addr <= img_addr + 6'd1;
            end
        end
    end

    assign datain = img_data;

endmodule

// File: tb/tb_lcd_cmd_seq.sv
`timescale 1ns/1ps
// Self-checking bench for lcd_cmd_seq. A simple controller model raises busy
// one cycle after each cmd_valid; an image memory model answers reads with
// one cycle of latency. Expected issue order comes from a queue of legal
// pushes; Load streams are checked byte by byte against the memory contents.
module tb_lcd_cmd_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] host_cmd = 3'd0;
    logic       host_valid = 1'b0;
    logic       host_ready;
    logic       img_rd;
    logic [5:0] img_addr;
    logic [7:0] img_data = 8'd0;
    logic       busy;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic [7:0] datain;
    logic       cmd_done;
    logic       cmd_err;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [64];
    logic       busy_force = 1'b0;
    int         ctl_cnt = 0;

    // Reference model state
    logic [2:0] exp_q [$];
    int         exp_err = 0;

    // Monitor state
    int   iss_cnt  = 0;
    int   done_cnt = 0;
    int   err_cnt  = 0;
    int   ld_t     = -1;
    int   since_valid = 100;
    logic prev_busy = 1'b0;

    logic [2:0] bp_codes [5] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd0};

    always #5 clk = ~clk;

    assign busy = busy_force | (ctl_cnt != 0);

    lcd_cmd_seq #(
        .FIFO_DEPTH(4),
        .IMG_BYTES (36)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .host_cmd  (host_cmd),
        .host_valid(host_valid),
        .host_ready(host_ready),
        .img_rd    (img_rd),
        .img_addr  (img_addr),
        .img_data  (img_data),
        .busy      (busy),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .datain    (datain),
        .cmd_done  (cmd_done),
        .cmd_err   (cmd_err)
    );

    // Image memory: one cycle read latency.
    always @(posedge clk) begin
        if (img_rd) img_data <= mem[img_addr];
    end

    // Controller: busy rises the cycle after cmd_valid and stays up for a
    // load window (38 cycles) or a short random time for other commands.
    always @(posedge clk or negedge reset) begin
        if (!reset)              ctl_cnt <= 0;
        else if (cmd_valid)      ctl_cnt <= (cmd == 3'd1) ? 38 : 1 + int'($urandom_range(3));
        else if (ctl_cnt != 0)   ctl_cnt <= ctl_cnt - 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            ld_t        = -1;
            since_valid = 100;
            prev_busy   = 1'b0;
        end else begin
            if (cmd_valid) begin
                iss_cnt++;
                check("valid_spacing", since_valid >= 4, 1);
                check("busy_low_before_issue", prev_busy, 0);
                check("issue_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("issue_order", cmd, exp_q.pop_front());
                if (cmd == 3'd1) ld_t = 0;
                since_valid = 1;
            end else begin
                since_valid++;
            end
            if (ld_t >= 0) begin
                if (ld_t <= 35) begin
                    check("stream_img_rd", img_rd, 1);
                    check("stream_addr", img_addr, ld_t);
                end
                if (ld_t >= 1) check("stream_datain", datain, mem[ld_t-1]);
                if (ld_t == 36) begin
                    check("stream_img_rd_off", img_rd, 0);
                    ld_t = -1;
                end else begin
                    ld_t++;
                end
            end
            if (cmd_done) done_cnt++;
            if (cmd_err)  err_cnt++;
            prev_busy = busy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] code);
        int n = 0;
        while (!host_ready && n < 500) begin
            tick();
            n++;
        end
        check("push_ready", host_ready, 1);
        if (host_ready) begin
            if (code >= 3'd6) exp_err++;
            else              exp_q.push_back(code);
        end
        host_cmd   = code;
        host_valid = 1'b1;
        tick();
        host_valid = 1'b0;
    endtask

    task automatic push_try(input logic [2:0] code, output logic rdy);
        rdy = host_ready;
        if (rdy) begin
            if (code >= 3'd6) exp_err++;
            else              exp_q.push_back(code);
        end
        host_cmd   = code;
        host_valid = 1'b1;
        tick();
        host_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || done_cnt != iss_cnt || err_cnt != exp_err || busy)
               && n < 3000) begin
            tick();
            n++;
        end
        check(tag, n < 3000, 1);
        repeat (3) tick();
    endtask

    initial begin
        int   b, d, e, n, nlegal, nill, gap;
        logic r;
        logic [2:0] code;

        for (int k = 0; k < 64; k++) mem[k] = 8'(k + 16);

        // Reset state
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd", cmd, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_img_rd", img_rd, 0);
        check("rst_img_addr", img_addr, 0);
        check("rst_cmd_done", cmd_done, 0);
        check("rst_cmd_err", cmd_err, 0);
        check("rst_host_ready", host_ready, 1);
        reset = 1'b1;
        tick();
        tick();

        // Load with idle controller: issue two cycles after the push cycle
        b = iss_cnt;
        push(3'd1);
        check("load_lat_p1", cmd_valid, 0);
        tick();
        check("load_valid", cmd_valid, 1);
        check("load_cmd", cmd, 1);
        check("load_addr0", img_addr, 0);
        repeat (36) tick();
        check("load_last_byte", datain, 8'h33);
        check("load_img_rd_low", img_rd, 0);
        wait_drain("load_drain");
        check("load_issues", iss_cnt - b, 1);

        // Busy holdoff
        busy_force = 1'b1;
        push(3'd2);
        repeat (10) begin
            check("hold_no_valid", cmd_valid, 0);
            tick();
        end
        busy_force = 1'b0;
        tick();
        check("hold_valid", cmd_valid, 1);
        check("hold_cmd", cmd, 2);
        d = done_cnt;
        wait_drain("hold_drain");
        check("hold_done", done_cnt - d, 1);

        // Backpressure: four accepted, fifth refused
        busy_force = 1'b1;
        b = iss_cnt;
        for (int i = 0; i < 5; i++) begin
            push_try(bp_codes[i], r);
            check("bp_ready", r, (i < 4) ? 1 : 0);
        end
        check("bp_full", host_ready, 0);
        repeat (4) tick();
        busy_force = 1'b0;
        wait_drain("bp_drain");
        check("bp_issues", iss_cnt - b, 4);
        check("bp_last_cmd", cmd, 5);

        // Illegal code dropped
        b = iss_cnt;
        e = err_cnt;
        push(3'd7);
        push(3'd4);
        wait_drain("ill_drain");
        check("ill_errs", err_cnt - e, 1);
        check("ill_issues", iss_cnt - b, 1);
        check("ill_cmd_hold", cmd, 4);

        // Back-to-back commands
        b = iss_cnt;
        d = done_cnt;
        push(3'd1);
        push(3'd4);
        push(3'd0);
        wait_drain("b2b_drain");
        check("b2b_issues", iss_cnt - b, 3);
        check("b2b_dones", done_cnt - d, 3);

        // Reset in the middle of a Load stream
        push(3'd1);
        n = 0;
        while (!(img_rd && img_addr == 6'd10) && n < 100) begin
            tick();
            n++;
        end
        check("mid_reach_k10", n < 100, 1);
        reset = 1'b0;
        #1;
        check("mid_img_rd", img_rd, 0);
        check("mid_img_addr", img_addr, 0);
        check("mid_cmd", cmd, 0);
        check("mid_cmd_valid", cmd_valid, 0);
        check("mid_host_ready", host_ready, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        // The aborted Load never completes; resynchronise the tallies.
        exp_q.delete();
        done_cnt = iss_cnt;
        err_cnt  = exp_err;
        tick();
        check("post_img_rd", img_rd, 0);
        check("post_host_ready", host_ready, 1);
        check("post_cmd_done", cmd_done, 0);
        push(3'd1);
        tick();
        check("restart_valid", cmd_valid, 1);
        check("restart_addr0", img_addr, 0);
        check("restart_img_rd", img_rd, 1);
        wait_drain("restart_drain");

        // Random traffic
        for (int k = 0; k < 64; k++) mem[k] = 8'($urandom);
        b = iss_cnt;
        d = done_cnt;
        e = err_cnt;
        nlegal = 0;
        nill   = 0;
        for (int i = 0; i < 40; i++) begin
            code = 3'($urandom_range(7));
            if (code >= 3'd6) nill++;
            else              nlegal++;
            busy_force = ($urandom_range(5) == 0);
            gap = int'($urandom_range(6));
            repeat (gap) tick();
            busy_force = 1'b0;
            push(code);
        end
        wait_drain("rand_drain");
        check("rand_issues", iss_cnt - b, nlegal);
        check("rand_dones", done_cnt - d, nlegal);
        check("rand_errs", err_cnt - e, nill);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_cmd_seq.md
# lcd_cmd_seq

Command sequencer that sits directly upstream of the LCD controller. It accepts host display commands into a small FIFO and issues them one at a time on the controller's `cmd`/`cmd_valid` port, only when the controller's `busy` is low. For Load commands it streams the 36-byte 6x6 image from a 1-cycle-latency image memory onto `datain`, cycle-aligned with the controller's load window.

## Interface
- `FIFO_DEPTH`, 4, command FIFO entries (power of 2, ≥2)
- `IMG_BYTES`, 36, bytes streamed per Load

- `clk` in 1: single clock, all logic on rising edge
- `reset` in 1: asynchronous, active-low (0 = reset)
- `host_cmd` in 3: host command code (0 Reflash, 1 Load, 2 Right, 3 Left, 4 Up, 5 Down)
- `host_valid` in 1: host offers `host_cmd` this cycle
- `host_ready` out 1: FIFO not full; push occurs when `host_valid & host_ready`
- `img_rd` out 1: image memory read strobe
- `img_addr` out 6: image memory address
- `img_data` in 8: memory read data, valid the cycle after `img_rd`
- `busy` in 1: controller busy
- `cmd` out 3: command to controller
- `cmd_valid` out 1: one-cycle issue strobe
- `datain` out 8: image byte to controller, combinational pass-through of `img_data`
- `cmd_done` out 1: one-cycle pulse when an issued command completes (controller `busy` seen low after GUARD)
- `cmd_err` out 1: one-cycle pulse when an illegal code (6, 7) is dropped

## Operation
- Reset values: `cmd`=0, `cmd_valid`=0, `img_rd`=0, `img_addr`=0, `cmd_done`=0, `cmd_err`=0, FIFO empty, so `host_ready`=1. State goes to IDLE. Reset mid-stream aborts the stream immediately; there is no resume.
- FIFO: `host_ready` = count < FIFO_DEPTH, from the registered count. When full, a push in the same cycle as a pop is still refused. Push and pop in the same non-full cycle leave the count unchanged.
- States:
  - IDLE: if the FIFO is non-empty and the head is 6 or 7, pop it, pulse `cmd_err`, stay in IDLE; one pop per cycle.
  - IDLE: else if the FIFO is non-empty and `busy`=0, go to ISSUE.
  - ISSUE (1 cycle): `cmd_valid`=1, `cmd`=head, pop. If the head is Load, start the stream this same cycle. Next state is GUARD.
  - GUARD (1 cycle): ignore `busy`, because the controller asserts it with a one-cycle lag. Next state is WAIT.
  - WAIT: hold until `busy`=0 and the stream is idle, then pulse `cmd_done` and go to IDLE.
- Stream: 6-bit counter k runs 0..IMG_BYTES-1. `img_rd`=1 and `img_addr`=k at issue cycle T+k. `img_rd` drops after k=35, and the counter does not wrap.
- `cmd` holds its last value between issues. `cmd_valid` is never high for two consecutive cycles.

## Timing
- Issue latency: a command pushed at cycle P into an empty FIFO with `busy`=0 gives `cmd_valid` at P+2 (FIFO write at P, IDLE decision at P+1, ISSUE at P+2).
- Load alignment: `cmd_valid` at T, `img_addr` k at T+k, `datain`=mem[k] at T+1+k for k = 0..35. The last byte is at T+36.
- Minimum spacing between `cmd_valid` pulses is 4 cycles (ISSUE, GUARD, WAIT ≥1, IDLE ≥1).
- `busy` high in IDLE blocks issue indefinitely; the FIFO keeps accepting pushes until full.
- `cmd_err` can pulse back-to-back for consecutive illegal entries. An illegal entry is never sent to the controller.

## Test plan
- Reset: drive `reset`=0 mid-Load at stream k=10, then release → all outputs are at their reset values next cycle, `img_rd`=0, FIFO empty, `host_ready`=1, and a fresh Load restarts at `img_addr`=0.
- Load: mem[k]=k+8'h10; push Load with controller idle → `cmd_valid`&`cmd`=1 at T, `datain`=8'h10 at T+1 … 8'h33 at T+36, `img_rd` low from T+36.
- Busy holdoff: hold `busy`=1, push Right → no `cmd_valid`; release `busy` at cycle B → `cmd_valid`, `cmd`=2 at B+1; `cmd_done` pulses after `busy` falls.
- Backpressure: hold `busy`=1, push 5 commands → `host_ready`=0 after 4, 5th refused; release `busy` → exactly 4 issues in push order.
- Illegal code: push 7, then 4 → `cmd_err` one pulse, `cmd_valid` only for `cmd`=4.
- Back-to-back: push Load, Up, Reflash → three `cmd_valid` pulses; each waits for `busy` low; three `cmd_done` pulses.
